// File: rtl/ahb_wbm_bridge.sv
// ahb_wbm_bridge: AHB slave to Wishbone B3 master bridge; byte lanes are swapped between the
// big-endian AHB side and the little-endian Wishbone side, and fixed AHB bursts become tagged WB bursts.
module ahb_wbm_bridge #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ahbsi_hsel,
  input  logic        ahbsi_hwrite,
  input  logic        ahbsi_hready,
  input  logic [31:0] ahbsi_haddr,
  input  logic [31:0] ahbsi_hwdata,
  input  logic [1:0]  ahbsi_htrans,
  input  logic [2:0]  ahbsi_hsize,
  input  logic [2:0]  ahbsi_hburst,
  output logic        ahbso_hready,
  output logic [1:0]  ahbso_hresp,
  output logic [31:0] ahbso_hrdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);
  typedef enum logic [2:0] {IDLE, ACCESS, HOLD, ERR1, ERR2} state_t;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state_q, state_d, nxt;
  logic [31:0] adr_q, adr_d;
  logic [3:0] sel_q, sel_d, cnt_q, cnt_d, sel_new;
  logic we_q, we_d, burst_q, burst_d;
  logic [1:0] bte_q, bte_d, hresp_q, hresp_d, hb;
  logic [TW-1:0] tmo_q, tmo_d;
  logic resp, ack_ok, acc, aerr, busy, tmo_exp;
  assign wbm_dat_o = {ahbsi_hwdata[7:0], ahbsi_hwdata[15:8], ahbsi_hwdata[23:16], ahbsi_hwdata[31:24]};
  assign ahbso_hrdata = {wbm_dat_i[7:0], wbm_dat_i[15:8], wbm_dat_i[23:16], wbm_dat_i[31:24]};
  assign resp = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign ack_ok = (state_q == ACCESS) & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
  assign ahbso_hready = (state_q == ACCESS) ? ack_ok : (state_q != ERR1);
  assign ahbso_hresp = (state_q == ERR1 || state_q == ERR2) ? hresp_q : 2'b00;
  assign acc = ahbsi_hsel & ahbsi_hready & ahbso_hready & ahbsi_htrans[1];
  assign busy = ahbsi_hsel & ahbsi_hready & (ahbsi_htrans == 2'b01);
  assign aerr = (ahbsi_hsize > 3'd2) | ((ahbsi_hsize == 3'd1) & ahbsi_haddr[0]) |
                ((ahbsi_hsize == 3'd2) & (|ahbsi_haddr[1:0]));
  assign sel_new = (ahbsi_hsize == 3'd0) ? 4'b0001 << ahbsi_haddr[1:0] :
                   (ahbsi_hsize == 3'd1) ? (ahbsi_haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign hb = ahbsi_hburst[2:1];
  assign tmo_exp = (TIMEOUT != 0) && (tmo_q == TMAX);
  assign nxt = acc ? (aerr ? ERR1 : ACCESS) : IDLE;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o = we_q;
  assign wbm_bte_o = bte_q;
  assign wbm_cyc_o = (state_q == ACCESS) | (state_q == HOLD);
  assign wbm_stb_o = state_q == ACCESS;
  assign wbm_cti_o = burst_q ? (|cnt_q ? 3'b010 : 3'b111) : 3'b000;
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    sel_d = sel_q;
    we_d = we_q;
    cnt_d = cnt_q;
    burst_d = burst_q;
    bte_d = bte_q;
    hresp_d = hresp_q;
    tmo_d = ((state_q == ACCESS) && !resp) ? tmo_q + 1'b1 : '0;
    case (state_q)
      ACCESS: begin
        if (wbm_err_i || wbm_rty_i) begin
          state_d = ERR1;
          hresp_d = wbm_err_i ? 2'b01 : 2'b10;
        end else if (wbm_ack_i) begin
          state_d = (busy && burst_q && |cnt_q) ? HOLD : nxt;
        end else if (tmo_exp) begin
          state_d = ERR1;
          hresp_d = 2'b01;
        end
      end
      HOLD: state_d = busy ? HOLD : nxt;
      ERR1: state_d = ERR2;
      default: state_d = nxt;
    endcase
    if (ack_ok && |cnt_q) cnt_d = cnt_q - 4'd1;
    if (acc && aerr) hresp_d = 2'b01;
    if (acc && !aerr) begin
      adr_d = {ahbsi_haddr[31:2], 2'b00};
      sel_d = sel_new;
      we_d = ahbsi_hwrite;
      // NONSEQ starts a new burst; SEQ keeps the running beat count
      if (!ahbsi_htrans[0]) begin
        cnt_d = {hb == 2'd3, hb[1], |hb, |hb};
        burst_d = |hb;
        bte_d = ahbsi_hburst[0] ? 2'b00 : hb;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
      burst_q <= 1'b0;
      bte_q <= '0;
      hresp_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      sel_q <= sel_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      burst_q <= burst_d;
      bte_q <= bte_d;
      hresp_q <= hresp_d;
      tmo_q <= tmo_d;
    end
  end
endmodule
